snake_writer: RTL and testbench

Game-logic writer for the map RAM. The renderer reads this RAM, and this block is the write-side producer.
- On every game tick it advances the snake one cell and runs wall and self collision checks.
- It erases the old tail cell and paints the new head cell through a held-request/ack write port.
- It sits between the user-input debouncers and the map RAM write port, and drives score to the 7-segment display path.

---
 rtl/snake_pkg.sv | 14 +
 rtl/snake_writer_if.sv | 9 +
 rtl/snake_body_fifo.sv | 45 ++++
 rtl/snake_writer.sv | 176 +++++++++++++++++
 tb/tb_snake_writer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake map writer
package snake_pkg;
  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_MOVE, S_CHECK, S_ERASE, S_DRAW, S_OVER} state_t;
  typedef struct packed {logic [7:0] r, g, b;} color_t;
  typedef struct packed {logic [9:0] x, y;} pos_t;
  localparam color_t COLOR_SNAKE = '{r: 8'd0, g: 8'd255, b: 8'd0};
  localparam color_t COLOR_EMPTY = '{r: 8'd0, g: 8'd0, b: 8'd0};
  localparam logic [19:0] SCORE_MAX = 20'd999999;
  // Up/down and left/right differ only in bit 0, so opposites xor to 01
  function automatic logic is_opposite(dir_t a, dir_t b);
    return (a ^ b) == 2'b01;
  endfunction
endpackage

// File: rtl/snake_writer_if.sv
// snake_writer_if: held-request/ack write port into the map RAM
interface snake_writer_if;
  logic       mapa_we;
  logic       mapa_ack;
  logic [9:0] mapa_wx, mapa_wy;
  logic [7:0] mapa_wR, mapa_wG, mapa_wB;
  modport master(output mapa_we, mapa_wx, mapa_wy, mapa_wR, mapa_wG, mapa_wB, input mapa_ack);
  modport slave(input mapa_we, mapa_wx, mapa_wy, mapa_wR, mapa_wG, mapa_wB, output mapa_ack);
endinterface

// File: rtl/snake_body_fifo.sv
// snake_body_fifo: circular buffer of snake cells with push-head, pop-tail and head-relative reads
module snake_body_fifo
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  localparam int PW = $clog2(MAX_LEN),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          ld_i,
  input  pos_t          pos_i,
  input  logic [PW-1:0] idx_i,
  output pos_t          rd_o,
  output pos_t          head_o,
  output pos_t          tail_o,
  output logic [LW-1:0] len_o
);
  pos_t          mem_q [MAX_LEN];
  logic [PW-1:0] head_q, tail_q, wr_ptr;
  logic [LW-1:0] len_q;
  // The initial body occupies slots 0..INIT_LEN-1 (tail at 0), loaded head-relative during INIT
  assign wr_ptr = push_i ? head_q + PW'(1) : head_q - idx_i;
  // Cell storage: pushes land one past the head, loads address relative to the head
  always_ff @(posedge clk)
    if (push_i || ld_i) mem_q[wr_ptr] <= pos_i;
  // Pointer and length bookkeeping
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head_q <= PW'(INIT_LEN - 1);
      tail_q <= '0;
      len_q  <= LW'(INIT_LEN);
    end else begin
      if (push_i) head_q <= head_q + PW'(1);
      if (pop_i) tail_q <= tail_q + PW'(1);
      len_q <= len_q + LW'(push_i) - LW'(pop_i);
    end
  assign rd_o   = mem_q[head_q - idx_i];
  assign head_o = mem_q[head_q];
  assign tail_o = mem_q[tail_q];
  assign len_o  = len_q;
endmodule

// File: rtl/snake_writer.sv
// snake_writer: snake game logic driving the map RAM write port; define SNAKE_WRAP_EN for wrapping edges
module snake_writer
  import snake_pkg::*;
#(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int MAX_LEN     = 64,
  parameter int INIT_LEN    = 3,
  parameter int TICK_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  input  logic eat,
  snake_writer_if.master mapa,
  output logic [19:0] score,
  output logic game_over,
  output logic busy
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  state_t        state_q;
  dir_t          dir_q, next_dir_q, req;
  logic [TW-1:0] tick_cnt_q;
  logic          tick, tick_pend_q, grow_q, we_q, game_over_q;
  logic          req_v, at_l, at_r, at_u, at_d, hit_wall, eff_grow, last, last_init, match;
  pos_t          nh_q, nh_d, head, tail, rd, init_pos;
  logic [PW-1:0] idx_q;
  logic [LW-1:0] len;
  logic [9:0]    wx_q, wy_q;
  color_t        col_q;
  logic [19:0]   score_q;

  snake_body_fifo #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) u_body (
    .clk(clk),
    .reset(reset),
    .push_i(state_q == S_DRAW && we_q && mapa.mapa_ack),
    .pop_i(state_q == S_ERASE && we_q && mapa.mapa_ack),
    .ld_i(state_q == S_INIT && !we_q),
    .pos_i(state_q == S_INIT ? init_pos : nh_q),
    .idx_i(idx_q),
    .rd_o(rd),
    .head_o(head),
    .tail_o(tail),
    .len_o(len)
  );

  assign tick = tick_cnt_q == TW'(TICK_CYCLES - 1);
  // Free-running game tick divider
  always_ff @(posedge clk or negedge reset)
    if (!reset) tick_cnt_q <= '0;
    else tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);

  assign req   = up ? DIR_UP : down ? DIR_DOWN : left ? DIR_LEFT : DIR_RIGHT;
  assign req_v = (up | down | left | right) && state_q != S_OVER && !is_opposite(req, dir_q);
  // Remember the latest legal direction request until the next move commits it
  always_ff @(posedge clk or negedge reset)
    if (!reset) next_dir_q <= DIR_RIGHT;
    else if (req_v) next_dir_q <= req;

  // Food counter for the display path
  always_ff @(posedge clk or negedge reset)
    if (!reset) score_q <= '0;
    else if (eat && state_q != S_OVER && score_q != SCORE_MAX) score_q <= score_q + 20'd1;

  assign at_l = head.x == 10'd0;
  assign at_r = head.x == 10'(MAPA_WIDTH - 1);
  assign at_u = head.y == 10'd0;
  assign at_d = head.y == 10'(MAPA_HEIGHT - 1);
  // Next head position; edge cases wrap, and are only kept when wrapping is enabled
  always_comb begin
    nh_d.x = dir_q == DIR_LEFT ? (at_l ? 10'(MAPA_WIDTH - 1) : head.x - 10'd1) :
             dir_q == DIR_RIGHT ? (at_r ? 10'd0 : head.x + 10'd1) : head.x;
    nh_d.y = dir_q == DIR_UP ? (at_u ? 10'(MAPA_HEIGHT - 1) : head.y - 10'd1) :
             dir_q == DIR_DOWN ? (at_d ? 10'd0 : head.y + 10'd1) : head.y;
  end
`ifdef SNAKE_WRAP_EN
  assign hit_wall = 1'b0;
`else
  assign hit_wall = (dir_q == DIR_LEFT && at_l) || (dir_q == DIR_RIGHT && at_r) ||
                    (dir_q == DIR_UP && at_u) || (dir_q == DIR_DOWN && at_d);
`endif

  assign init_pos  = '{x: 10'(MAPA_WIDTH / 2) - 10'(idx_q), y: 10'(MAPA_HEIGHT / 2)};
  assign last_init = idx_q == PW'(INIT_LEN - 1);
  assign eff_grow  = grow_q && len != LW'(MAX_LEN);
  assign last      = idx_q == PW'(len - LW'(1));
  assign match     = rd == nh_q && (!last || eff_grow);

  // Main sequencer: owns the write port, direction commit and the pending tick/grow flags
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= S_INIT;
      dir_q       <= DIR_RIGHT;
      tick_pend_q <= 1'b0;
      grow_q      <= 1'b0;
      nh_q        <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      wx_q        <= '0;
      wy_q        <= '0;
      col_q       <= COLOR_EMPTY;
      game_over_q <= 1'b0;
    end else begin
      if (tick && state_q != S_IDLE) tick_pend_q <= 1'b1;
      if (eat && state_q != S_OVER) grow_q <= 1'b1;
      case (state_q)
        S_INIT:
          if (!we_q) begin
            we_q  <= 1'b1;
            wx_q  <= init_pos.x;
            wy_q  <= init_pos.y;
            col_q <= COLOR_SNAKE;
          end else if (mapa.mapa_ack) begin
            we_q    <= 1'b0;
            idx_q   <= last_init ? '0 : idx_q + PW'(1);
            state_q <= last_init ? S_IDLE : S_INIT;
          end
        S_IDLE:
          if (tick || tick_pend_q) begin
            state_q     <= S_MOVE;
            tick_pend_q <= 1'b0;
            dir_q       <= next_dir_q;
          end
        S_MOVE: begin
          nh_q        <= nh_d;
          idx_q       <= '0;
          state_q     <= hit_wall ? S_OVER : S_CHECK;
          game_over_q <= hit_wall;
        end
        S_CHECK:
          if (match) begin
            state_q     <= S_OVER;
            game_over_q <= 1'b1;
          end else if (last) begin
            state_q <= eff_grow ? S_DRAW : S_ERASE;
            grow_q  <= eat;
          end else idx_q <= idx_q + PW'(1);
        S_ERASE:
          if (!we_q) begin
            we_q  <= 1'b1;
            wx_q  <= tail.x;
            wy_q  <= tail.y;
            col_q <= COLOR_EMPTY;
          end else if (mapa.mapa_ack) begin
            we_q    <= 1'b0;
            state_q <= S_DRAW;
          end
        S_DRAW:
          if (!we_q) begin
            we_q  <= 1'b1;
            wx_q  <= nh_q.x;
            wy_q  <= nh_q.y;
            col_q <= COLOR_SNAKE;
          end else if (mapa.mapa_ack) begin
            we_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        default: we_q <= 1'b0;
      endcase
    end

  assign mapa.mapa_we = we_q;
  assign mapa.mapa_wx = wx_q;
  assign mapa.mapa_wy = wy_q;
  assign mapa.mapa_wR = col_q.r;
  assign mapa.mapa_wG = col_q.g;
  assign mapa.mapa_wB = col_q.b;
  assign score        = score_q;
  assign game_over    = game_over_q;
  assign busy         = state_q != S_IDLE && state_q != S_OVER;
endmodule

// File: tb/tb_snake_writer.sv
// tb_snake_writer: scoreboard bench for snake_writer, default build or SNAKE_WRAP_EN
`timescale 1ns/1ps
module tb_snake_writer;
  import snake_pkg::*;
  localparam int TICK = 64;
  logic clk = 0, rst_a = 0, rst_b = 0, up = 0, down = 0, left = 0, right = 0, eat = 0;
  logic ack = 1, sel = 0;
  logic [19:0] score_a, score_b, m_score;
  logic go_a, go_b, busy_a, busy_b, m_go, m_busy, m_we;
  logic [45:0] m_wr;
  logic [45:0] exp_q[$];
  int bx[$], by[$];
  int mw, mh, checks = 0, errors = 0, stall_cnt = 0;
  bit stalling = 0;

  snake_writer_if ifa();
  snake_writer_if ifb();

  snake_writer #(.TICK_CYCLES(TICK)) dut_a (
    .clk(clk), .reset(rst_a), .up(up), .down(down), .left(left), .right(right), .eat(eat),
    .mapa(ifa), .score(score_a), .game_over(go_a), .busy(busy_a));

  snake_writer #(.MAPA_WIDTH(8), .MAPA_HEIGHT(6), .INIT_LEN(5), .TICK_CYCLES(TICK)) dut_b (
    .clk(clk), .reset(rst_b), .up(up), .down(down), .left(left), .right(right), .eat(eat),
    .mapa(ifb), .score(score_b), .game_over(go_b), .busy(busy_b));

  assign ifa.mapa_ack = sel ? 1'b1 : ack;
  assign ifb.mapa_ack = sel ? ack : 1'b1;
  assign m_we    = sel ? ifb.mapa_we : ifa.mapa_we;
  assign m_wr    = sel ? {ifb.mapa_wx, ifb.mapa_wy, ifb.mapa_wR, ifb.mapa_wG, ifb.mapa_wB}
                       : {ifa.mapa_wx, ifa.mapa_wy, ifa.mapa_wR, ifa.mapa_wG, ifa.mapa_wB};
  assign m_go    = sel ? go_b : go_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_score = sel ? score_b : score_a;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int x, input int y, input bit green);
    exp_q.push_back({10'(x), 10'(y), green ? 24'h00FF00 : 24'h000000});
  endtask

  // Write responder and scoreboard: optional ack stall on a green write, pop on every completed write
  initial forever begin
    @(negedge clk);
    if (m_we && stall_cnt > 0 && m_wr[15:8] == 8'hFF) stalling = 1;
    if (stalling) begin
      ack = 0;
      stall_cnt--;
      chk("stall_we", m_we, 1);
      chk("stall_wr", m_wr, exp_q.size() != 0 ? exp_q[0] : '1);
      if (stall_cnt == 0) stalling = 0;
    end else begin
      ack = 1;
      if (m_we) begin
        if (exp_q.size() != 0) chk("write", m_wr, exp_q.pop_front());
        else chk("unexpected_write", m_wr, '1);
      end
    end
  end

  task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic e);
    up = u; down = d; left = l; right = r; eat = e;
    @(negedge clk);
    {up, down, left, right, eat} = '0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3 * TICK) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic model_init(input int w, input int h, input int n);
    mw = w;
    mh = h;
    bx.delete();
    by.delete();
    for (int i = 0; i < n; i++) begin
      bx.push_back(w / 2 - i);
      by.push_back(h / 2);
      push_exp(w / 2 - i, h / 2, 1);
    end
  endtask

  task automatic step(input dir_t d, input bit grow, input string tag);
    int nx, ny;
    bit dead;
    nx = bx[0] + (d == DIR_RIGHT ? 1 : d == DIR_LEFT ? -1 : 0);
    ny = by[0] + (d == DIR_DOWN ? 1 : d == DIR_UP ? -1 : 0);
`ifdef SNAKE_WRAP_EN
    nx = (nx + mw) % mw;
    ny = (ny + mh) % mh;
    dead = 0;
`else
    dead = nx < 0 || nx >= mw || ny < 0 || ny >= mh;
`endif
    for (int i = 0; i < bx.size() - (grow ? 0 : 1); i++)
      if (bx[i] == nx && by[i] == ny) dead = 1;
    if (dead) begin
      int n = 0;
      while (!m_go && n < 3 * TICK) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_over"}, m_go, 1);
      repeat (2 * TICK) @(negedge clk);
      chk({tag, "_busy"}, m_busy, 0);
      chk({tag, "_still_over"}, m_go, 1);
    end else begin
      if (!grow) begin
        push_exp(bx[$], by[$], 0);
        void'(bx.pop_back());
        void'(by.pop_back());
      end
      push_exp(nx, ny, 1);
      bx.push_front(nx);
      by.push_front(ny);
      wait_drain(tag);
      chk({tag, "_over"}, m_go, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_we", m_we, 0);
    chk("rst_wr", m_wr, 0);
    chk("rst_score", m_score, 0);
    chk("rst_over", m_go, 0);
    chk("rst_busy", m_busy, 1);
    model_init(40, 30, 3);
    rst_a = 1;
    wait_drain("init");
    chk("init_busy", m_busy, 0);
    stall_cnt = 5;
    step(DIR_RIGHT, 0, "move1");
    chk("stall_used", stall_cnt, 0);
    pulse(0, 0, 1, 0, 0);
    step(DIR_RIGHT, 0, "reverse");
    pulse(1, 0, 1, 0, 0);
    step(DIR_UP, 0, "up_wins");
    pulse(0, 0, 0, 1, 1);
    step(DIR_RIGHT, 1, "grow");
    chk("score", m_score, 1);
    while (bx[0] != 39) step(DIR_RIGHT, 0, "run");
    step(DIR_RIGHT, 0, "edge");
    sel = 1;
    model_init(8, 6, 5);
    rst_b = 1;
    wait_drain("init_b");
    pulse(1, 0, 0, 0, 0);
    step(DIR_UP, 0, "b_up");
    pulse(0, 0, 1, 0, 0);
    step(DIR_LEFT, 0, "b_left");
    pulse(0, 1, 0, 0, 0);
    step(DIR_DOWN, 0, "b_self");
    chk("b_score", m_score, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
